// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants and helpers for the elastic pipeline
package pipeline_pkg;

    localparam int STALL_BUBBLE = 0;
    localparam int STALL_HOLD   = 1;

    // Occupancy counts 0..depth inclusive, so it needs one more code than depth.
    function automatic int clog2p1(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipeline_elastic_unit_if.sv
// rtl/pipeline_elastic_unit_if.sv - producer/consumer handshake bundle for the elastic pipeline
interface pipeline_elastic_unit_if #(
    parameter int WIDTH = 32
) ();

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );

endinterface

// File: rtl/pipeline_stage.sv
// rtl/pipeline_stage.sv - one valid+data slice of the elastic pipeline
module pipeline_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             flush,
    input  logic             bubble_clr,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (bubble_clr) begin
            valid <= 1'b0;
        end else if (en) begin
            valid <= src_valid;
            // Data only moves with a valid source so an empty stage keeps its last value.
            if (src_valid) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/pipeline_elastic_unit.sv
// rtl/pipeline_elastic_unit.sv - DEPTH-stage stallable, flushable pipeline with bubble collapse
module pipeline_elastic_unit
    import pipeline_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 3,
    parameter int STALL_MODE = STALL_HOLD
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          stall,
    pipeline_elastic_unit_if.slave        bus,
    output logic [clog2p1(DEPTH)-1:0]     occupancy
);

    localparam int  OW          = clog2p1(DEPTH);
    localparam logic BUBBLE_MODE = (STALL_MODE == STALL_BUBBLE);

    logic [DEPTH:0]   valid;
    logic [WIDTH-1:0] data [DEPTH+1];
    logic [DEPTH:1]   en_raw;
    logic [DEPTH:1]   en;
    logic             hold;
    logic             bubble_clr;

    assign valid[0] = bus.in_valid;
    assign data[0]  = bus.in_data;

    // Enables ripple from the output back so any empty stage lets upstream advance.
    always_comb begin
        en_raw        = '0;
        en_raw[DEPTH] = !valid[DEPTH] || bus.out_ready;
        for (int i = DEPTH - 1; i >= 1; i--) begin
            en_raw[i] = !valid[i] || en_raw[i+1];
        end
    end

    assign hold       = stall || flush;
    assign en         = hold ? '0 : en_raw;
    assign bubble_clr = stall && BUBBLE_MODE;

    for (genvar i = 1; i <= DEPTH; i++) begin : g_stage
        pipeline_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .reset_n    (reset_n),
            .en         (en[i]),
            .flush      (flush),
            .bubble_clr (bubble_clr),
            .src_valid  (valid[i-1]),
            .src_data   (data[i-1]),
            .valid      (valid[i]),
            .data       (data[i])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            occupancy = occupancy + OW'(valid[i]);
        end
    end

    // Output valid is masked so no consumer handshake can complete during stall or flush.
    assign bus.in_ready  = en[1];
    assign bus.out_valid = valid[DEPTH] && !hold;
    assign bus.out_data  = data[DEPTH];

endmodule

// File: tb/tb_pipeline_elastic_unit.sv
// tb/tb_pipeline_elastic_unit.sv - scoreboard bench running BUBBLE and HOLD instances side by side
module tb_pipeline_elastic_unit;

    localparam int W = 32;
    localparam int D = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          stall;
    logic          in_valid;
    logic          out_ready;
    logic [W-1:0]  in_data;

    logic [1:0]    occ_b;
    logic [1:0]    occ_h;
    logic [1:0]    rdy;
    logic [1:0]    ov;
    logic [W-1:0]  od [2];
    logic [1:0]    occ [2];

    int total = 0;
    int bad   = 0;

    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];

    always #5 clk = ~clk;

    pipeline_elastic_unit_if #(.WIDTH(W)) bus_b ();
    pipeline_elastic_unit_if #(.WIDTH(W)) bus_h ();

    assign bus_b.in_data   = in_data;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.out_ready = out_ready;
    assign bus_h.in_data   = in_data;
    assign bus_h.in_valid  = in_valid;
    assign bus_h.out_ready = out_ready;

    assign rdy[0] = bus_b.in_ready;
    assign rdy[1] = bus_h.in_ready;
    assign ov[0]  = bus_b.out_valid;
    assign ov[1]  = bus_h.out_valid;
    assign od[0]  = bus_b.out_data;
    assign od[1]  = bus_h.out_data;
    assign occ[0] = occ_b;
    assign occ[1] = occ_h;

    pipeline_elastic_unit #(.WIDTH(W), .DEPTH(D), .STALL_MODE(0)) u_bub (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .stall     (stall),
        .bus       (bus_b.slave),
        .occupancy (occ_b)
    );

    pipeline_elastic_unit #(.WIDTH(W), .DEPTH(D), .STALL_MODE(1)) u_hold (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .stall     (stall),
        .bus       (bus_h.slave),
        .occupancy (occ_h)
    );

    task automatic chk(input string name, input int m, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s mode=%0d actual=%0h required=%0h t=%0t", name, m, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void qpush(input int m, input logic [W-1:0] v);
        if (m == 0) q0.push_back(v);
        else        q1.push_back(v);
    endfunction

    function automatic void qclear(input int m);
        if (m == 0) q0.delete();
        else        q1.delete();
    endfunction

    function automatic logic [W-1:0] qpop(input int m);
        if (m == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Reference: a pipeline of DEPTH slots behaves as a bounded in-order queue;
    // flush empties it, and a BUBBLE-mode stall empties it as well.
    task automatic step(input logic iv, input logic [W-1:0] id, input logic fl,
                        input logic st, input logic ordy);
        logic exp_rdy;
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = id;
        flush     = fl;
        stall     = st;
        out_ready = ordy;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            exp_rdy = !fl && !st && (qsize(m) < D || ordy);
            chk("in_ready", m, {31'b0, rdy[m]}, {31'b0, exp_rdy});
            chk("occupancy", m, {30'b0, occ[m]}, qsize(m));
            if (fl || (st && m == 0)) qclear(m);
            else if (iv && exp_rdy)   qpush(m, id);
        end
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (reset_n === 1'b1) begin
            for (int m = 0; m < 2; m++) begin
                if (ov[m]) begin
                    chk("out_valid_masked", m, {31'b0, (stall || flush)}, '0);
                    if (out_ready) begin
                        if (qsize(m) == 0) chk("unexpected_output", m, od[m], 32'hFFFF_FFFF);
                        else               chk("out_data", m, od[m], qpop(m));
                    end
                end
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD;
        flush     = 1'b0;
        stall     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("reset_out_valid", m, {31'b0, ov[m]}, '0);
            chk("reset_out_data", m, od[m], '0);
            chk("reset_occupancy", m, {30'b0, occ[m]}, '0);
        end
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 2; m++) chk("post_reset_in_ready", m, {31'b0, rdy[m]}, 32'd1);

        // Streaming latency: first output visible after the third edge.
        for (int v = 1; v <= 4; v++) begin
            step(1'b1, v, 1'b0, 1'b0, 1'b1);
            for (int m = 0; m < 2; m++) begin
                chk("stream_out_valid", m, {31'b0, ov[m]}, (v == 4) ? 32'd1 : 32'd0);
                if (v == 4) begin
                    chk("stream_first_data", m, od[m], 32'd1);
                    chk("stream_occupancy", m, {30'b0, occ[m]}, 32'd3);
                end
            end
        end
        drain(5);

        // Backpressure: fourth entry refused until the consumer opens up.
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hD, 1'b0, 1'b0, 1'b0);
        for (int m = 0; m < 2; m++) chk("full_refuses", m, {31'b0, rdy[m]}, '0);
        step(1'b1, 32'hD, 1'b0, 1'b0, 1'b1);
        drain(5);

        // Bubble collapse: late entries slide up behind a blocked head.
        step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int m = 0; m < 2; m++) chk("collapse_occupancy", m, {30'b0, occ[m]}, 32'd3);
        drain(5);

        // Stall mid-stream.
        step(1'b1, 32'd1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'd2, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'd3, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'd4, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'd4, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'd4, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'd5, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'd6, 1'b0, 1'b0, 1'b1);
        drain(5);

        // Flush with concurrent stall and offered input.
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hE, 1'b1, 1'b1, 1'b1);
        for (int m = 0; m < 2; m++) chk("flush_out_valid", m, {31'b0, ov[m]}, '0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int m = 0; m < 2; m++) begin
            chk("flush_occupancy", m, {30'b0, occ[m]}, '0);
            chk("flush_out_data", m, od[m], '0);
        end
        drain(3);

        // Randomized traffic.
        repeat (400) begin
            step(1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 99) < 3),
                 1'($urandom_range(0, 99) < 6),
                 1'($urandom_range(0, 99) < 70));
        end
        drain(8);
        for (int m = 0; m < 2; m++) chk("drained", m, qsize(m), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_elastic_unit.md
Name: pipeline_elastic_unit

Overview:
Parametrised successor to the fixed 3-stage pipeline. It is a DEPTH-stage, WIDTH-bit register pipeline with valid/ready backpressure and bubble collapsing. It supports a selectable global-stall mode (legacy bubble-drop or lossless hold) and a single-cycle flush, and reports stage occupancy. It sits between a producer and a consumer datapath wherever a fixed-latency, stallable, flushable delay line is needed.

Parameters:
WIDTH, 32, data width in bits (>=1)
DEPTH, 3, number of register stages (>=1); stage 1 is the input side, stage DEPTH drives the outputs
STALL_MODE, 1, 0 = BUBBLE (legacy: stall invalidates all stages, data held), 1 = HOLD (stall freezes data and valid)

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  synchronous, active-low reset
in_data  input  WIDTH  producer data
in_valid  input  1  producer has data
in_ready  output  1  pipeline accepts in_data this cycle
flush  input  1  discard all contents (single-cycle pulse or level)
stall  input  1  global stall
out_data  output  WIDTH  stage DEPTH data
out_valid  output  1  stage DEPTH holds a deliverable entry
out_ready  input  1  consumer accepts
occupancy  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Interface: one clock; reset is synchronous and active-low (ports clk and reset_n).
- Priority at each rising edge: reset_n==0 > flush > stall > normal advance.
- Reset: all stage valid bits and data cleared to 0. Hence out_valid=0, out_data=0, occupancy=0. in_ready=1 once reset_n=1 and stall=flush=0.
- Stage state: valid_i, data_i for i=1..DEPTH. A stage loads only when valid, so data never changes while valid_i=0, except on reset or flush.
- Advance enables, computed combinationally from DEPTH down to 1:
  - en_DEPTH = !valid_DEPTH || out_ready
  - en_i = !valid_i || en_{i+1}
  - All en forced 0 when stall or flush is high.
- in_ready = en_1.
- Input transfer: in_valid && in_ready.
- Output transfer: out_valid && out_ready.
- On en_i: valid_i <= valid_{i-1} (stage 0 = in_valid) and data_i <= data_{i-1}, but data only when the source is valid. Otherwise the stage holds.
- Bubble collapse: an empty stage always accepts from upstream even when downstream is blocked. A full chain with out_ready=0 holds exactly DEPTH entries.
- Latency: an entry accepted at edge t is presented on out_valid after edge t+DEPTH-1, provided there is no backpressure. Throughput is 1/cycle.
- out_valid = valid_DEPTH && !stall && !flush (masked, so no handshake completes during stall or flush). out_data = data_DEPTH, unmasked.
- Flush: at the edge, all valid_i<=0 and data_i<=0. The input offered in that cycle is dropped (in_ready=0). No entry is delivered in the flush cycle.
- Stall, HOLD mode: all stages keep data and valid. in_ready=0. No loss, no duplication.
- Stall, BUBBLE mode: at each stalled edge all valid_i<=0 and data_i is held. Entries are discarded; after the stall, the first delivered entry is the first one accepted post-stall.
- occupancy = popcount(valid_1..valid_DEPTH), combinational, unmasked by stall or flush.
- Simultaneous flush and stall: flush applies. Reset asserted mid-stream clears everything at that edge regardless of other inputs.
- DEPTH=1: single register; en_1 = !valid_1 || out_ready.

Decomposition:
- Shared package pipeline_pkg holds the constants STALL_BUBBLE=0 and STALL_HOLD=1, and an occupancy-width function clog2p1(DEPTH).
- Sub-module pipeline_stage holds one valid+data slice with en, flush, and bubble-clear inputs. It is instantiated DEPTH times via generate; the enable chain and output masking stay in the top.

Test Plan:
1. Reset: hold reset_n=0 for 2 edges with in_valid=1, in_data=0xDEAD -> out_valid=0, out_data=0, occupancy=0; after release in_ready=1.
2. Streaming (DEPTH=3, out_ready=1): send 1,2,3,4 on consecutive cycles from edge t -> out_valid first high after edge t+2 with out_data=1, then 2,3,4 on consecutive cycles; occupancy settles at 3.
3. Backpressure: out_ready=0, send 0xA,0xB,0xC,0xD -> 0xA,0xB,0xC accepted, in_ready=0 while offering 0xD, occupancy=3; raise out_ready -> outputs 0xA,0xB,0xC,0xD in order, no loss or duplication.
4. Bubble collapse: out_ready=0, send 0x55; after 3 idle cycles send 0x66 then 0x77 -> 0x55 at stage 3, 0x66 at stage 2, 0x77 at stage 1, occupancy=3, both accepted without stalling.
5. Stall modes: stream 1..6, assert stall for 2 cycles mid-stream. HOLD -> out_valid=0 during the stall, then the sequence resumes gap-free with all values. BUBBLE -> the entries in flight at stall are lost and the next value out is the first accepted after stall drops.
6. Flush: pipeline full (0xA,0xB,0xC), out_ready=1, pulse flush together with in_valid=1, in_data=0xE, and stall=1 -> out_valid=0 that cycle; after the edge occupancy=0, out_data=0; 0xE never appears at the output.
